// File: rtl/csa_segment_precompute.sv
// csa_segment_precompute
//   Two-stage operand front end of a carry-select adder. For every BITS-wide
//   segment it precomputes both conditional results (segment carry-in 0 and
//   carry-in 1) and registers them for the downstream per-segment select muxes.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   a, b, cin         : operand beat (W = BITS*SEGMENTS bits) and carry-in
//   in_valid/in_ready : operand handshake
//   sum0/cout0        : per-segment sum/carry assuming segment carry-in 0
//   sum1/cout1        : per-segment sum/carry assuming segment carry-in 1
//   sel0              : registered cin, select for the segment-0 mux
//   out_valid/out_ready : result handshake
module csa_segment_precompute #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned SEGMENTS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS*SEGMENTS-1:0] a,
  input  logic [BITS*SEGMENTS-1:0] b,
  input  logic                     cin,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BITS*SEGMENTS-1:0] sum0,
  output logic [SEGMENTS-1:0]      cout0,
  output logic [BITS*SEGMENTS-1:0] sum1,
  output logic [SEGMENTS-1:0]      cout1,
  output logic                     sel0,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned W = BITS * SEGMENTS;

  // Stage A: operand register
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                cin_q;
  logic                va_q;

  // Stage B: result register
  logic [W-1:0]        sum0_q;
  logic [W-1:0]        sum1_q;
  logic [SEGMENTS-1:0] cout0_q;
  logic [SEGMENTS-1:0] cout1_q;
  logic                sel0_q;
  logic                vb_q;

  logic [W-1:0]        sum0_d;
  logic [W-1:0]        sum1_d;
  logic [SEGMENTS-1:0] cout0_d;
  logic [SEGMENTS-1:0] cout1_d;
  logic [BITS:0]       seg0;
  logic [BITS:0]       seg1;

  logic                adv_b;

  // Stage B drains when empty or when downstream takes its beat; stage A
  // follows B, so the only combinational path is out_ready -> in_ready.
  assign adv_b    = !vb_q || out_ready;
  assign in_ready = !va_q || adv_b;

  // Independent per-segment adds; no carry crosses a segment boundary here.
  always_comb begin
    sum0_d  = '0;
    sum1_d  = '0;
    cout0_d = '0;
    cout1_d = '0;
    seg0    = '0;
    seg1    = '0;
    for (int unsigned k = 0; k < SEGMENTS; k++) begin
      seg0 = {1'b0, a_q[k*BITS +: BITS]} + {1'b0, b_q[k*BITS +: BITS]};
      seg1 = {1'b0, a_q[k*BITS +: BITS]} + {1'b0, b_q[k*BITS +: BITS]}
             + (BITS+1)'(1);
      sum0_d[k*BITS +: BITS] = seg0[BITS-1:0];
      sum1_d[k*BITS +: BITS] = seg1[BITS-1:0];
      cout0_d[k]             = seg0[BITS];
      cout1_d[k]             = seg1[BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      if (in_ready) begin
        va_q <= in_valid;
      end
      if (in_ready && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_q    <= 1'b0;
      sum0_q  <= '0;
      sum1_q  <= '0;
      cout0_q <= '0;
      cout1_q <= '0;
      sel0_q  <= 1'b0;
    end else begin
      if (adv_b) begin
        vb_q <= va_q;
      end
      if (adv_b && va_q) begin
        sum0_q  <= sum0_d;
        sum1_q  <= sum1_d;
        cout0_q <= cout0_d;
        cout1_q <= cout1_d;
        sel0_q  <= cin_q;
      end
    end
  end

  assign sum0      = sum0_q;
  assign sum1      = sum1_q;
  assign cout0     = cout0_q;
  assign cout1     = cout1_q;
  assign sel0      = sel0_q;
  assign out_valid = vb_q;

endmodule

// File: tb/tb_csa_segment_precompute.sv
module tb_csa_segment_precompute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] sum0;
  logic [3:0]  cout0;
  logic [31:0] sum1;
  logic [3:0]  cout1;
  logic        sel0;
  logic        out_valid;
  logic        out_ready = 1'b1;

  csa_segment_precompute #(.BITS(8), .SEGMENTS(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum0(sum0), .cout0(cout0), .sum1(sum1), .cout1(cout1),
    .sel0(sel0), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    longint      acc;   // edge number at which the beat was accepted
  } beat_t;

  beat_t  q[$];
  int     checks = 0;
  int     failures = 0;
  longint edges = 0;
  logic   last_xin = 1'b0;
  int     n_in = 0;
  int     n_out = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each segment is an independent 8-bit add, carry-in 0 or 1.
  function automatic void model(input logic [31:0] a_, input logic [31:0] b_,
                                output logic [31:0] s0, output logic [3:0] c0,
                                output logic [31:0] s1, output logic [3:0] c1);
    int unsigned x, y, f;
    s0 = '0; s1 = '0; c0 = '0; c1 = '0;
    for (int k = 0; k < 4; k++) begin
      x = (a_ >> (8*k)) & 32'hFF;
      y = (b_ >> (8*k)) & 32'hFF;
      f = x + y;
      s0 = s0 | ((f & 32'hFF) << (8*k));
      c0[k] = (f > 255);
      f = f + 1;
      s1 = s1 | ((f & 32'hFF) << (8*k));
      c1[k] = (f > 255);
    end
  endfunction

  // Carry-select resolution as the downstream mux chain does it.
  function automatic logic [31:0] resolve(input logic [31:0] s0, input logic [3:0] c0,
                                          input logic [31:0] s1, input logic [3:0] c1,
                                          input logic sel);
    logic [31:0] r;
    logic        c;
    r = '0;
    c = sel;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = c ? s1[8*k +: 8] : s0[8*k +: 8];
      c = c ? c1[k] : c0[k];
    end
    return r;
  endfunction

  task automatic check_front();
    logic [31:0] s0, s1, r;
    logic [3:0]  c0, c1;
    model(q[0].a, q[0].b, s0, c0, s1, c1);
    chk("sum0", {32'h0, sum0}, {32'h0, s0});
    chk("cout0", {60'h0, cout0}, {60'h0, c0});
    chk("sum1", {32'h0, sum1}, {32'h0, s1});
    chk("cout1", {60'h0, cout1}, {60'h0, c1});
    chk("sel0", {63'h0, sel0}, {63'h0, q[0].cin});
    r = q[0].a + q[0].b + 32'(q[0].cin);
    chk("resolved", {32'h0, resolve(sum0, cout0, sum1, cout1, sel0)}, {32'h0, r});
  endtask

  // One clock cycle: called just after a falling edge with inputs driven.
  task automatic cycle();
    logic exp_ov, exp_ir, xin, xout;
    #1;
    exp_ov = (q.size() > 0) && (q[0].acc < edges);
    exp_ir = !((q.size() == 2) && !out_ready);
    chk("out_valid", {63'h0, out_valid}, {63'h0, exp_ov});
    chk("in_ready", {63'h0, in_ready}, {63'h0, exp_ir});
    if (exp_ov) check_front();
    xin  = in_valid && exp_ir;
    xout = exp_ov && out_ready;
    @(posedge clk);
    edges++;
    if (xout) begin
      void'(q.pop_front());
      n_out++;
    end
    if (xin) begin
      q.push_back('{a: a, b: b, cin: cin, acc: edges});
      n_in++;
    end
    last_xin = xin;
    @(negedge clk);
  endtask

  task automatic lit_outputs(input string name, input logic [31:0] s0, input logic [3:0] c0,
                             input logic [31:0] s1, input logic [3:0] c1, input logic sl);
    chk({name, "_valid"}, {63'h0, out_valid}, 64'h1);
    chk({name, "_sum0"}, {32'h0, sum0}, {32'h0, s0});
    chk({name, "_cout0"}, {60'h0, cout0}, {60'h0, c0});
    chk({name, "_sum1"}, {32'h0, sum1}, {32'h0, s1});
    chk({name, "_cout1"}, {60'h0, cout1}, {60'h0, c1});
    chk({name, "_sel0"}, {63'h0, sel0}, {63'h0, sl});
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_out_valid"}, {63'h0, out_valid}, 64'h0);
    chk({name, "_in_ready"}, {63'h0, in_ready}, 64'h1);
    chk({name, "_sum0"}, {32'h0, sum0}, 64'h0);
    chk({name, "_sum1"}, {32'h0, sum1}, 64'h0);
    chk({name, "_couts"}, {56'h0, cout1, cout0}, 64'h0);
    chk({name, "_sel0"}, {63'h0, sel0}, 64'h0);
  endtask

  initial begin
    logic [31:0] s0, s1;
    logic [3:0]  c0, c1;

    // Reset state
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed literal vectors
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h000000FF; b = 32'h00000001; cin = 1'b0;
    cycle();
    a = 32'hFFFFFFFF; b = 32'h00000000; cin = 1'b1;
    cycle();
    #1;
    lit_outputs("vec1", 32'h00000000, 4'b0001, 32'h01010101, 4'b0001, 1'b0);
    in_valid = 1'b0;
    cycle();
    #1;
    lit_outputs("vec2", 32'hFFFFFFFF, 4'b0000, 32'h00000000, 4'b1111, 1'b1);
    cycle();
    cycle();

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Stall: three beats offered with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h12345678; b = 32'h9ABCDEF0; cin = 1'b1;
    cycle();
    a = 32'h00FF00FF; b = 32'h00010001; cin = 1'b0;
    cycle();
    a = 32'hDEADBEEF; b = 32'h01020304; cin = 1'b1;
    #1;
    chk("stall_third_ready", {63'h0, in_ready}, 64'h0);
    model(32'h12345678, 32'h9ABCDEF0, s0, c0, s1, c1);
    cycle();
    cycle();
    #1;
    lit_outputs("stall_hold", s0, c0, s1, c1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (last_xin) in_valid = 1'b0;
      cycle();
    end

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h11111111; b = 32'h22222222; cin = 1'b0;
    cycle();
    a = 32'h33333333; b = 32'h44444444; cin = 1'b1;
    cycle();
    in_valid = 1'b0;
    #2;
    chk("prereset_full_valid", {63'h0, out_valid}, 64'h1);
    rst = 1'b1;
    #1;
    chk_reset_state("midreset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h0000FF00; b = 32'h00000100; cin = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    #1;
    lit_outputs("postreset", 32'h00000000, 4'b0010, 32'h01010101, 4'b0010, 1'b0);
    cycle();

    // Random handshake traffic
    n_in = 0; n_out = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!in_valid || last_xin) begin
        in_valid = 1'($urandom_range(0, 1));
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    if (last_xin) in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (last_xin) in_valid = 1'b0;
      cycle();
    end
    chk("drain_empty", {32'h0, 32'(q.size())}, 64'h0);
    chk("in_out_count", {32'h0, 32'(n_out)}, {32'h0, 32'(n_in)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
